code_memory_loader: RTL and testbench

- Boot-time loader that sits directly upstream of the Nios II code memory's s1 write port.
- Receives a framed byte stream (from a UART/JTAG byte source) over a valid/ready handshake.
- Assembles little-endian 32-bit words and writes them into code memory.
- Holds the CPU in reset until an image loads with a valid checksum.

---
 rtl/code_memory_loader.sv | 274 +++++++++++++++++++++++++++
 tb/tb_code_memory_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_memory_loader.sv
// -----------------------------------------------------------------------------
// code_memory_loader
//
// Boot-time loader placed in front of the Nios II code memory s1 write port.
// It receives a framed byte stream over a valid/ready handshake. It assembles
// little-endian 32-bit words, writes them into code memory and keeps the CPU in
// reset until an image with a valid checksum has been written.
//
// Frame: 0xA5 | START[15:0] | COUNT[15:0] | COUNT*4 data bytes | CHK
//        CHK is the modulo-256 sum of the data bytes only.
//
// Ports:
//   clk             single clock
//   reset           synchronous, active-high reset
//   in_data         stream byte
//   in_valid        in_data is valid
//   in_ready        loader accepts in_data this cycle (independent of in_valid)
//   mem_address     word address to code memory
//   mem_writedata   assembled write word
//   mem_byteenable  byte enables, constant 4'hF
//   mem_chipselect  memory select, high only in the write cycle
//   mem_write       write strobe, high only in the write cycle
//   cpu_reset_req   holds CPU / memory clock-enable in reset while high
//   load_done       image loaded and verified (sticky until reset)
//   load_error      load aborted (sticky until reset)
//   error_code      0 none, 1 range, 2 checksum, 3 timeout
//   words_written   words committed in the current frame
// -----------------------------------------------------------------------------
module code_memory_loader #(
  parameter int ADDR_WIDTH     = 14,
  parameter int DEPTH          = 12288,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_writedata,
  output logic [3:0]            mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic                  cpu_reset_req,
  output logic                  load_done,
  output logic                  load_error,
  output logic [1:0]            error_code,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam int                 AW1        = ADDR_WIDTH + 1;
  localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]         SYNC       = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_CHECKSUM = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_t;

  state_t             state, next_state;
  err_t               next_err;
  logic [1:0]         hdr_idx;
  logic [1:0]         lane;
  logic [15:0]        start_q;
  logic [15:0]        count_q;
  logic [AW1-1:0]     addr_q;
  logic [3:0][7:0]    word_q;
  logic [7:0]         chk_sum;
  logic [TIMER_W-1:0] timer;

  logic               accept;
  logic               timer_expired;
  logic [15:0]        count_full;
  logic [16:0]        range_end;
  logic               range_bad;
  logic [AW1-1:0]     ww_next;
  logic               last_word;
  logic               addr_ok;

  assign accept        = in_ready & in_valid;
  assign timer_expired = (timer == TIMER_LAST);

  // COUNT's high byte arrives on the 4th header byte, so the range check
  // uses the incoming byte directly instead of waiting a cycle.
  assign count_full = {in_data, count_q[7:0]};
  assign range_end  = {1'b0, start_q} + {1'b0, count_full};
  assign range_bad  = (count_full == 16'd0) || (range_end > 17'(DEPTH));

  assign ww_next   = words_written + AW1'(1);
  assign last_word = (32'(ww_next) == 32'(count_q));

  // Always true once the header check has passed; the extra address bit
  // exists so the final increment past DEPTH-1 cannot alias to address 0.
  assign addr_ok = (addr_q < AW1'(DEPTH));

  assign mem_byteenable = 4'hF;

  // ---------------------------------------------------------------------------
  // State register
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of process ordering.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. An accepted byte always takes priority over a timer
  // expiring in the same cycle.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    next_err   = ERR_NONE;
    case (state)
      S_IDLE: begin
        if (accept && in_data == SYNC) next_state = S_HDR;
      end
      S_HDR: begin
        if (accept) begin
          if (hdr_idx == 2'd3) begin
            if (range_bad) begin
              next_state = S_ERROR;
              next_err   = ERR_RANGE;
            end else begin
              next_state = S_DATA;
            end
          end
        end else if (timer_expired) begin
          next_state = S_ERROR;
          next_err   = ERR_TIMEOUT;
        end
      end
      S_DATA: begin
        if (accept) begin
          if (lane == 2'd3) next_state = S_WRITE;
        end else if (timer_expired) begin
          next_state = S_ERROR;
          next_err   = ERR_TIMEOUT;
        end
      end
      S_WRITE: begin
        next_state = last_word ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (accept) begin
          if (in_data == chk_sum) begin
            next_state = S_DONE;
          end else begin
            next_state = S_ERROR;
            next_err   = ERR_CHECKSUM;
          end
        end else if (timer_expired) begin
          next_state = S_ERROR;
          next_err   = ERR_TIMEOUT;
        end
      end
      S_DONE:  next_state = S_DONE;
      S_ERROR: next_state = S_ERROR;
      default: next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: header capture, word assembly, checksum, timer, counters.
  // The timer only advances in HDR/DATA/CHK; WRITE leaves it untouched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_idx       <= '0;
      lane          <= '0;
      start_q       <= '0;
      count_q       <= '0;
      addr_q        <= '0;
      word_q        <= '0;
      chk_sum       <= '0;
      timer         <= '0;
      words_written <= '0;
      error_code    <= ERR_NONE;
    end else begin
      if (state != S_ERROR && next_state == S_ERROR) error_code <= next_err;

      case (state)
        S_IDLE: begin
          if (accept && in_data == SYNC) begin
            hdr_idx       <= '0;
            lane          <= '0;
            chk_sum       <= '0;
            timer         <= '0;
            words_written <= '0;
          end
        end
        S_HDR: begin
          if (accept) begin
            timer   <= '0;
            hdr_idx <= hdr_idx + 2'd1;
            case (hdr_idx)
              2'd0: start_q[7:0]  <= in_data;
              2'd1: start_q[15:8] <= in_data;
              2'd2: count_q[7:0]  <= in_data;
              2'd3: begin
                count_q[15:8] <= in_data;
                addr_q        <= AW1'(start_q);
              end
            endcase
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DATA: begin
          if (accept) begin
            timer        <= '0;
            word_q[lane] <= in_data;
            lane         <= lane + 2'd1;
            chk_sum      <= chk_sum + in_data;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WRITE: begin
          words_written <= ww_next;
          addr_q        <= addr_q + AW1'(1);
        end
        S_CHK: begin
          if (accept) timer <= '0;
          else        timer <= timer + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. While reset is asserted every output shows its reset value, so
  // the CPU stays held and no byte is taken even before the first reset edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready       = 1'b0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    cpu_reset_req  = 1'b1;
    load_done      = 1'b0;
    load_error     = 1'b0;
    if (!reset) begin
      case (state)
        S_IDLE, S_HDR, S_DATA, S_CHK: in_ready = 1'b1;
        S_WRITE: begin
          mem_chipselect = addr_ok;
          mem_write      = addr_ok;
          mem_address    = addr_q[ADDR_WIDTH-1:0];
          mem_writedata  = word_q;
        end
        S_DONE: begin
          cpu_reset_req = 1'b0;
          load_done     = 1'b1;
        end
        S_ERROR: load_error = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_code_memory_loader.sv
// -----------------------------------------------------------------------------
// tb_code_memory_loader
//
// Directed bench for code_memory_loader. Bytes are driven at the falling edge
// and outputs sampled away from the rising edge. A negedge monitor logs every
// memory write and counts handshake/strobe rule breaks.
// -----------------------------------------------------------------------------
module tb_code_memory_loader;

  localparam int AW    = 14;
  localparam int DEPTH = 12288;
  localparam int TO    = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_writedata;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect;
  logic          mem_write;
  logic          cpu_reset_req;
  logic          load_done;
  logic          load_error;
  logic [1:0]    error_code;
  logic [AW:0]   words_written;

  code_memory_loader #(
    .ADDR_WIDTH    (AW),
    .DEPTH         (DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect),
    .mem_write     (mem_write),
    .cpu_reset_req (cpu_reset_req),
    .load_done     (load_done),
    .load_error    (load_error),
    .error_code    (error_code),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [AW-1:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_n = 0;
  int          viol = 0;
  logic        prev_wr = 1'b0;
  logic [31:0] tx_words [16];

  // Write log and protocol monitor: in_ready is low exactly in write cycles
  // while a frame is active, strobes last one cycle, byte enables are full.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_write) begin
        if (wr_n < 64) begin
          wr_addr[wr_n] = mem_address;
          wr_data[wr_n] = mem_writedata;
        end
        wr_n++;
        if (mem_byteenable !== 4'hF || mem_chipselect !== 1'b1) viol++;
        if (prev_wr) viol++;
      end
      if (!load_done && !load_error && (in_ready === mem_write)) viol++;
    end
    prev_wr = mem_write;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input bit clear_log);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    if (clear_log) begin
      wr_n = 0;
      viol = 0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake: byte %h in_ready=%b required 1", b, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic gap(input int max_idle);
    repeat ($urandom_range(0, max_idle)) @(negedge clk);
  endtask

  task automatic send_header(input logic [15:0] start, input logic [15:0] count);
    send_byte(8'hA5);
    send_byte(start[7:0]);
    send_byte(start[15:8]);
    send_byte(count[7:0]);
    send_byte(count[15:8]);
  endtask

  task automatic send_data(input int count, input int max_idle);
    for (int w = 0; w < count; w++)
      for (int i = 0; i < 4; i++) begin
        if (max_idle > 0) gap(max_idle);
        send_byte(tx_words[w][8*i +: 8]);
      end
  endtask

  function automatic logic [7:0] calc_chk(input int count);
    logic [7:0] s;
    s = 8'h00;
    for (int w = 0; w < count; w++)
      for (int i = 0; i < 4; i++) s = s + tx_words[w][8*i +: 8];
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    checks++; if (mem_write !== 1'b0 || mem_chipselect !== 1'b0) begin errors++; $display("FAIL rst_strobes: got we=%b cs=%b required 0 0", mem_write, mem_chipselect); end
    checks++; if (mem_address !== '0 || mem_writedata !== '0) begin errors++; $display("FAIL rst_mem_bus: got addr=%h data=%h required 0 0", mem_address, mem_writedata); end
    checks++; if (mem_byteenable !== 4'hF) begin errors++; $display("FAIL rst_be: got %h required f", mem_byteenable); end
    checks++; if (cpu_reset_req !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset: got %b required 1", cpu_reset_req); end
    checks++; if (load_done !== 1'b0 || load_error !== 1'b0) begin errors++; $display("FAIL rst_flags: got done=%b err=%b required 0 0", load_done, load_error); end
    checks++; if (error_code !== 2'd0 || words_written !== '0) begin errors++; $display("FAIL rst_counters: got code=%0d ww=%0d required 0 0", error_code, words_written); end
    in_valid = 1'b0;
    reset    = 1'b0;
    wr_n     = 0;
    viol     = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_single_word();
    do_reset(1'b1);
    tx_words[0] = 32'h44332211;
    send_header(16'h0010, 16'h0001);
    send_data(1, 0);
    // Last data byte was accepted on the previous edge: strobe must be up now.
    checks++; if (mem_write !== 1'b1 || mem_address !== 14'h0010) begin errors++; $display("FAIL single_latency: got we=%b addr=%h required 1 0010", mem_write, mem_address); end
    @(posedge clk);
    #1;
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL single_strobe_width: got %b required 0", mem_write); end
    checks++; if (cpu_reset_req !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL single_pre_chk: got cpu=%b done=%b required 1 0", cpu_reset_req, load_done); end
    send_byte(8'hAA);
    checks++; if (cpu_reset_req !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL single_done: got cpu=%b done=%b required 0 1", cpu_reset_req, load_done); end
    checks++; if (wr_n !== 1 || wr_addr[0] !== 14'h0010 || wr_data[0] !== 32'h44332211) begin errors++; $display("FAIL single_write: got n=%0d addr=%h data=%h required 1 0010 44332211", wr_n, wr_addr[0], wr_data[0]); end
    checks++; if (words_written !== 15'd1 || error_code !== 2'd0) begin errors++; $display("FAIL single_count: got ww=%0d code=%0d required 1 0", words_written, error_code); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL single_protocol: got %0d violations required 0", viol); end
  endtask

  task automatic test_upper_boundary();
    do_reset(1'b1);
    tx_words[0] = 32'hCAFE0001;
    tx_words[1] = 32'hCAFE0002;
    send_header(16'h2FFE, 16'h0002);
    send_data(2, 0);
    send_byte(calc_chk(2));
    checks++; if (load_done !== 1'b1 || load_error !== 1'b0) begin errors++; $display("FAIL edge_done: got done=%b err=%b required 1 0", load_done, load_error); end
    checks++; if (wr_n !== 2 || wr_addr[0] !== 14'h2FFE || wr_addr[1] !== 14'h2FFF) begin errors++; $display("FAIL edge_addr: got n=%0d a0=%h a1=%h required 2 2ffe 2fff", wr_n, wr_addr[0], wr_addr[1]); end
    checks++; if (wr_data[1] !== 32'hCAFE0002) begin errors++; $display("FAIL edge_data: got %h required cafe0002", wr_data[1]); end

    do_reset(1'b1);
    send_header(16'h2FFF, 16'h0002);
    checks++; if (load_error !== 1'b1 || error_code !== 2'd1) begin errors++; $display("FAIL range_err: got err=%b code=%0d required 1 1", load_error, error_code); end
    checks++; if (in_ready !== 1'b0 || cpu_reset_req !== 1'b1) begin errors++; $display("FAIL range_hold: got rdy=%b cpu=%b required 0 1", in_ready, cpu_reset_req); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wr_n !== 0) begin errors++; $display("FAIL range_writes: got %0d required 0", wr_n); end

    do_reset(1'b1);
    send_header(16'h0000, 16'h0000);
    checks++; if (load_error !== 1'b1 || error_code !== 2'd1) begin errors++; $display("FAIL zero_count: got err=%b code=%0d required 1 1", load_error, error_code); end
  endtask

  task automatic test_bad_checksum();
    do_reset(1'b1);
    tx_words[0] = 32'h04030201;
    tx_words[1] = 32'h08070605;
    tx_words[2] = 32'hFFFEFDFC;
    send_header(16'h0100, 16'h0003);
    send_data(3, 0);
    send_byte(calc_chk(3) + 8'd1);
    checks++; if (wr_n !== 3 || wr_data[2] !== 32'hFFFEFDFC || wr_addr[2] !== 14'h0102) begin errors++; $display("FAIL badchk_writes: got n=%0d a2=%h d2=%h required 3 0102 fffefdfc", wr_n, wr_addr[2], wr_data[2]); end
    checks++; if (load_error !== 1'b1 || error_code !== 2'd2 || load_done !== 1'b0) begin errors++; $display("FAIL badchk_err: got err=%b code=%0d done=%b required 1 2 0", load_error, error_code, load_done); end
    checks++; if (cpu_reset_req !== 1'b1) begin errors++; $display("FAIL badchk_cpu: got %b required 1", cpu_reset_req); end
  endtask

  task automatic test_backpressure();
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) tx_words[i] = 32'h10203040 + 32'h01010101 * i;
    send_byte(8'h00); gap(3);
    send_byte(8'hFF); gap(3);
    send_byte(8'h00); gap(3);
    send_byte(8'hFF);
    send_header(16'h0200, 16'h0004);
    send_data(4, 4);
    gap(4);
    send_byte(calc_chk(4));
    checks++; if (load_done !== 1'b1 || words_written !== 15'd4) begin errors++; $display("FAIL bp_done: got done=%b ww=%0d required 1 4", load_done, words_written); end
    checks++; if (wr_n !== 4) begin errors++; $display("FAIL bp_count: got %0d required 4", wr_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr[i] !== 14'(16'h0200 + i) || wr_data[i] !== tx_words[i]) begin
        errors++;
        $display("FAIL bp_word%0d: got addr=%h data=%h required %h %h", i, wr_addr[i], wr_data[i], 14'(16'h0200 + i), tx_words[i]);
      end
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL bp_protocol: got %0d violations required 0", viol); end
  endtask

  task automatic test_timeout();
    do_reset(1'b1);
    tx_words[0] = 32'h0D0C0B0A;
    send_header(16'h0040, 16'h0001);
    send_byte(8'h0A);
    send_byte(8'h0B);
    repeat (TO - 1) @(posedge clk);
    send_byte(8'h0C);
    send_byte(8'h0D);
    send_byte(8'h0A + 8'h0B + 8'h0C + 8'h0D);
    checks++; if (load_done !== 1'b1 || load_error !== 1'b0) begin errors++; $display("FAIL stall15: got done=%b err=%b required 1 0", load_done, load_error); end

    do_reset(1'b1);
    send_header(16'h0040, 16'h0001);
    send_byte(8'h0A);
    repeat (TO - 1) @(posedge clk);
    #1;
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL stall_early: got err=%b required 0", load_error); end
    @(posedge clk);
    #1;
    checks++; if (load_error !== 1'b1 || error_code !== 2'd3 || cpu_reset_req !== 1'b1) begin errors++; $display("FAIL stall16: got err=%b code=%0d cpu=%b required 1 3 1", load_error, error_code, cpu_reset_req); end

    do_reset(1'b1);
    repeat (TO + 4) @(posedge clk);
    #1;
    checks++; if (load_error !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL idle_no_timeout: got err=%b rdy=%b required 0 1", load_error, in_ready); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset(1'b1);
    tx_words[0] = 32'h55667788;
    send_header(16'h0300, 16'h0002);
    send_byte(8'h88);
    send_byte(8'h77);
    @(posedge clk);
    do_reset(1'b0);
    tx_words[0] = 32'hA1A2A3A4;
    tx_words[1] = 32'hB1B2B3B4;
    send_header(16'h0030, 16'h0002);
    send_data(2, 0);
    send_byte(calc_chk(2));
    checks++; if (wr_n !== 2 || wr_addr[0] !== 14'h0030 || wr_addr[1] !== 14'h0031) begin errors++; $display("FAIL midrst_writes: got n=%0d a0=%h a1=%h required 2 0030 0031", wr_n, wr_addr[0], wr_addr[1]); end
    checks++; if (wr_data[0] !== 32'hA1A2A3A4 || wr_data[1] !== 32'hB1B2B3B4) begin errors++; $display("FAIL midrst_data: got %h %h required a1a2a3a4 b1b2b3b4", wr_data[0], wr_data[1]); end
    checks++; if (words_written !== 15'd2 || load_done !== 1'b1) begin errors++; $display("FAIL midrst_done: got ww=%0d done=%b required 2 1", words_written, load_done); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_upper_boundary();
    test_bad_checksum();
    test_backpressure();
    test_timeout();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
